// File: rtl/tx_sched.sv
// tx_sched: two-producer grant arbiter and transmitter kick scheduler
// for a ping-pong TX buffer of two 1024-byte halves.
module tx_sched #(
  parameter int IFG_CYC  = 12,
  parameter int KICK_TO  = 16,
  parameter int FRAME_TO = 1100
) (
  input  logic       clk125,
  input  logic       rst_n,
  input  logic [1:0] req,
  output logic [1:0] gnt,
  output logic       wr_half,
  input  logic       done,
  output logic       idx,
  input  logic       txctl,
  output logic [1:0] full_cnt,
  output logic       busy,
  output logic       err_to,
  input  logic       err_clr
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_KICK,
    S_BUSY,
    S_GAP
  } state_t;

  localparam logic [10:0] KICK_END  = 11'(KICK_TO - 1);
  localparam logic [10:0] FRAME_END = 11'(FRAME_TO - 1);
  localparam logic [10:0] IFG_END   = 11'(IFG_CYC - 1);

  state_t      r_state;
  logic [10:0] r_cnt;
  logic [1:0]  r_gnt;
  logic [1:0]  r_full;
  logic        r_wr_half;
  logic        r_ptr;
  logic        r_idx;
  logic        r_busy;
  logic        r_err;

  logic        w_inc;
  logic        w_kick_to;
  logic        w_frame_to;
  logic        w_rel;
  logic        w_dec;
  logic        w_grant;
  logic [1:0]  w_pick;

  assign w_inc = done && (r_gnt != 2'b00)
              && (r_full != 2'd2);

  assign w_kick_to = (r_state == S_KICK) && !txctl
                  && (r_cnt == KICK_END);

  assign w_frame_to = (r_state == S_BUSY) && txctl
                   && (r_cnt == FRAME_END);

  // A timed-out half is consumed just like a sent one.
  assign w_rel = w_kick_to || w_frame_to
              || ((r_state == S_BUSY) && !txctl);

  assign w_dec = w_rel && (r_full != 2'd0);

  assign w_grant = (r_gnt == 2'b00) && (r_full != 2'd2)
                && (req != 2'b00);

  always_comb begin
    w_pick = 2'b01;
    unique case (1'b1)
      (req == 2'b11): w_pick = r_ptr ? 2'b10 : 2'b01;
      (req == 2'b10): w_pick = 2'b10;
      default:        w_pick = 2'b01;
    endcase
  end

  always_ff @(posedge clk125 or negedge rst_n) begin
    if (!rst_n) begin
      r_gnt     <= 2'b00;
      r_wr_half <= 1'b1;
      r_ptr     <= 1'b0;
    end else if (w_inc) begin
      r_gnt     <= 2'b00;
      r_wr_half <= ~r_wr_half;
    end else if (w_grant) begin
      r_gnt <= w_pick;
      r_ptr <= w_pick[0];
    end
  end

  always_ff @(posedge clk125 or negedge rst_n) begin
    if (!rst_n) begin
      r_full <= 2'd0;
    end else if (w_inc && !w_dec) begin
      r_full <= r_full + 2'd1;
    end else if (w_dec && !w_inc) begin
      r_full <= r_full - 2'd1;
    end
  end

  always_ff @(posedge clk125 or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= 11'd0;
      r_idx   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (r_full != 2'd0) begin
            r_idx   <= ~r_idx;
            r_cnt   <= 11'd0;
            r_state <= S_KICK;
            r_busy  <= 1'b1;
          end
        end
        S_KICK: begin
          if (txctl) begin
            r_cnt   <= 11'd0;
            r_state <= S_BUSY;
          end else if (r_cnt == KICK_END) begin
            r_cnt   <= 11'd0;
            r_state <= S_GAP;
          end else begin
            r_cnt <= r_cnt + 11'd1;
          end
        end
        S_BUSY: begin
          if (!txctl || (r_cnt == FRAME_END)) begin
            r_cnt   <= 11'd0;
            r_state <= S_GAP;
          end else begin
            r_cnt <= r_cnt + 11'd1;
          end
        end
        S_GAP: begin
          // Gap restarts whenever the transmitter is still active.
          if (txctl) begin
            r_cnt <= 11'd0;
          end else if (r_cnt == IFG_END) begin
            r_cnt   <= 11'd0;
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 11'd1;
          end
        end
        default: begin
          r_cnt   <= 11'd0;
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk125 or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (w_kick_to || w_frame_to) begin
      r_err <= 1'b1;
    end else if (err_clr) begin
      r_err <= 1'b0;
    end
  end

  assign gnt      = r_gnt;
  assign wr_half  = r_wr_half;
  assign idx      = r_idx;
  assign full_cnt = r_full;
  assign busy     = r_busy;
  assign err_to   = r_err;

endmodule

// File: tb/tb_tx_sched.sv
// tb_tx_sched: scoreboard bench for tx_sched with a
// behavioural transmitter and two producers.
module tb_tx_sched;

  localparam int IFG = 12;
  localparam int KTO = 16;
  localparam int FTO = 1100;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] req;
  logic [1:0] gnt;
  logic       wr_half;
  logic       done;
  logic       idx;
  logic       txctl;
  logic [1:0] full_cnt;
  logic       busy;
  logic       err_to;
  logic       err_clr;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;

  logic       sb_q[$];
  logic [1:0] gnt_q[$];

  logic       m_wr_half;
  logic       prev_idx;
  logic [1:0] prev_gnt;
  logic [1:0] prev_fc;
  int         tx_mode;
  int         tx_ph;
  int         tx_n;
  int         fall_edge;
  logic       fall_seen;
  logic       chk_ifg;
  logic       tx_auto;
  logic       tx_man;

  always #4 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  assign txctl = (tx_mode == 0) ? tx_auto : tx_man;

  tx_sched #(
    .IFG_CYC (IFG),
    .KICK_TO (KTO),
    .FRAME_TO(FTO)
  ) dut (
    .clk125  (clk),
    .rst_n   (rst_n),
    .req     (req),
    .gnt     (gnt),
    .wr_half (wr_half),
    .done    (done),
    .idx     (idx),
    .txctl   (txctl),
    .full_cnt(full_cnt),
    .busy    (busy),
    .err_to  (err_to),
    .err_clr (err_clr)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp)
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    else
      n_pass++;
  endtask

  task automatic monitor();
    logic       e1;
    logic       ok;
    logic [1:0] e2;
    if (!rst_n) begin
      sb_q.delete();
      gnt_q.delete();
      tx_ph     = 0;
      tx_n      = 0;
      tx_auto   = 1'b0;
      fall_seen = 1'b0;
      prev_idx  = idx;
      prev_gnt  = gnt;
      prev_fc   = full_cnt;
      return;
    end
    if (gnt != 2'b00 && prev_gnt == 2'b00) begin
      ok = (prev_fc < 2'd2);
      chk("gnt_at_full", ok, 1);
      chk("wr_half_gnt", wr_half, m_wr_half);
      if (gnt_q.size() == 0) begin
        chk("gnt_q_empty", gnt_q.size(), 1);
      end else begin
        e2 = gnt_q.pop_front();
        chk("gnt_seq", gnt, e2);
      end
    end
    if (idx != prev_idx) begin
      ok = (full_cnt <= 2'd2);
      chk("fc_max", ok, 1);
      if (sb_q.size() == 0) begin
        chk("sb_empty", sb_q.size(), 1);
      end else begin
        e1 = sb_q.pop_front();
        chk("half", idx, e1);
      end
      if (fall_seen && chk_ifg)
        chk("ifg", cyc - fall_edge, IFG + 1);
      fall_seen = 1'b0;
      if (tx_mode == 0) begin
        tx_ph = 1;
        tx_n  = 0;
      end
    end else if (tx_ph == 1) begin
      tx_n++;
      if (tx_n == 4) begin
        tx_auto = 1'b1;
        tx_ph   = 2;
        tx_n    = 0;
      end
    end else if (tx_ph == 2) begin
      tx_n++;
      if (tx_n == 1052) begin
        tx_auto   = 1'b0;
        tx_ph     = 0;
        fall_edge = cyc + 1;
        fall_seen = 1'b1;
      end
    end
    prev_idx = idx;
    prev_gnt = gnt;
    prev_fc  = full_cnt;
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      monitor();
    end
  endtask

  task automatic pulse_done();
    done = 1'b1;
    sb_q.push_back(m_wr_half);
    m_wr_half = ~m_wr_half;
    tick(1);
    done = 1'b0;
  endtask

  task automatic wait_gnt();
    logic g;
    int   n = 0;
    while (gnt == 2'b00 && n < 4000) begin
      tick(1);
      n++;
    end
    g = (gnt != 2'b00);
    chk("gnt_wait", g, 1);
  endtask

  task automatic wait_toggle();
    logic old;
    logic e;
    int   n = 0;
    old = idx;
    while (idx == old && n < 3000) begin
      tick(1);
      n++;
    end
    e = ~old;
    chk("tog_wait", idx, e);
  endtask

  task automatic wait_idle();
    logic [2:0] s;
    int         n = 0;
    while ((busy || full_cnt != 2'd0) && n < 6000) begin
      tick(1);
      n++;
    end
    s = {busy, full_cnt};
    chk("idle_wait", s, 0);
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req       = 2'b00;
    done      = 1'b0;
    err_clr   = 1'b0;
    tx_man    = 1'b0;
    m_wr_half = 1'b1;
    tick(2);
    chk("rst_gnt", gnt, 0);
    chk("rst_wr_half", wr_half, 1);
    chk("rst_idx", idx, 0);
    chk("rst_fc", full_cnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err_to, 0);
    rst_n = 1'b1;
    tick(1);
  endtask

  initial begin
    rst_n   = 1'b0;
    req     = 2'b00;
    done    = 1'b0;
    err_clr = 1'b0;
    tx_man  = 1'b0;
    tx_auto = 1'b0;
    tx_mode = 0;
    tx_ph   = 0;
    tx_n    = 0;
    chk_ifg = 1'b0;
    fall_seen = 1'b0;
    m_wr_half = 1'b1;
    do_reset();

    // single producer, first frame
    gnt_q.push_back(2'b01);
    req = 2'b01;
    tick(1);
    chk("gnt_lat", gnt, 2'b01);
    chk("wr_half_a", wr_half, 1);
    req = 2'b00;
    tick(1030);
    chk("gnt_hold", gnt, 2'b01);
    pulse_done();
    chk("fc_a", full_cnt, 1);
    chk("gnt_clr", gnt, 0);
    chk("wr_half_tg", wr_half, 0);
    tick(1);
    chk("idx_a", idx, 1);
    chk("busy_a", busy, 1);
    wait_idle();
    done = 1'b1;
    tick(1);
    done = 1'b0;
    chk("done_ign_fc", full_cnt, 0);
    chk("done_ign_wh", wr_half, m_wr_half);

    // both producers, round robin and back-pressure
    do_reset();
    chk_ifg = 1'b1;
    gnt_q.push_back(2'b01);
    gnt_q.push_back(2'b10);
    gnt_q.push_back(2'b01);
    req = 2'b11;
    for (int k = 0; k < 3; k++) begin
      wait_gnt();
      tick(20);
      pulse_done();
      if (k == 1) begin
        tick(3);
        chk("fc_full", full_cnt, 2);
        chk("gnt_withheld", gnt, 0);
      end
    end
    req = 2'b00;
    wait_idle();
    chk_ifg = 1'b0;

    // silent transmitter: kick timeout
    tx_mode = 1;
    gnt_q.push_back(2'b01);
    req = 2'b01;
    wait_gnt();
    req = 2'b00;
    tick(5);
    pulse_done();
    wait_toggle();
    tick(KTO - 1);
    chk("err_pre", err_to, 0);
    tick(1);
    chk("err_set", err_to, 1);
    chk("fc_to", full_cnt, 0);
    chk("busy_to", busy, 1);
    tick(2);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    chk("err_clr", err_to, 0);
    gnt_q.push_back(2'b01);
    req = 2'b01;
    wait_gnt();
    req = 2'b00;
    tick(2);
    pulse_done();
    wait_toggle();
    tick(KTO - 2);
    err_clr = 1'b1;
    tick(2);
    chk("err_set_wins", err_to, 1);
    tick(1);
    chk("err_clr2", err_to, 0);
    err_clr = 1'b0;
    wait_idle();

    // done coincides with a busy release
    tx_mode = 2;
    tx_man  = 1'b0;
    gnt_q.push_back(2'b01);
    gnt_q.push_back(2'b01);
    req = 2'b01;
    wait_gnt();
    tick(5);
    pulse_done();
    wait_toggle();
    tick(3);
    tx_man = 1'b1;
    wait_gnt();
    req = 2'b00;
    tick(40);
    tx_man = 1'b0;
    pulse_done();
    chk("fc_same", full_cnt, 1);
    chk("busy_gap", busy, 1);
    chk("gnt_clr_e", gnt, 0);
    wait_toggle();
    tick(3);
    tx_man = 1'b1;
    tick(20);
    tx_man = 1'b0;
    wait_idle();

    // reset in the middle of a frame
    tx_mode = 0;
    gnt_q.push_back(2'b01);
    req = 2'b01;
    wait_gnt();
    req = 2'b00;
    tick(3);
    pulse_done();
    wait_toggle();
    tick(30);
    chk("busy_pre", busy, 1);
    do_reset();
    gnt_q.push_back(2'b01);
    req = 2'b11;
    wait_gnt();
    req = 2'b00;
    tick(3);
    pulse_done();
    wait_toggle();
    chk("first_tog", idx, 1);
    wait_idle();

    chk("sb_left", sb_q.size(), 0);
    chk("gq_left", gnt_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
